// File: rtl/palette_lut_fader.sv
// palette_lut_fader: writable colour palette with a frame-synchronous fader.
// A pixel index is looked up in a register palette (stage 1), then each
// channel is scaled by the current brightness level (stage 2).
//
// Optional build macro PALETTE_TRANSPARENT_EN adds a 'transparent' output.
// When it is defined, index 0 is shown as black and flagged transparent.
//
// Handshake: a palette write is accepted on a rising clock edge where
// wr_valid and wr_ready are both high. While wr_valid is high and wr_ready
// is low, the requester holds wr_addr/wr_data stable. wr_ready is low only
// while a fade is running.
//
// fade_state is a debug view of the fade FSM:
// 0 = FULL, 1 = FADING_OUT, 2 = BLACK, 3 = FADING_IN.
module palette_lut_fader #(
  parameter int INDEX_W  = 5,
  parameter int CH_W     = 4,
  parameter int FADE_DIV = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [INDEX_W-1:0]   index,
  input  logic                 pix_valid,
  output logic [CH_W-1:0]      red,
  output logic [CH_W-1:0]      green,
  output logic [CH_W-1:0]      blue,
  output logic                 rgb_valid,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*CH_W-1:0]    wr_data,
  input  logic                 frame_tick,
  input  logic [1:0]           fade_cmd,
  output logic                 fade_busy,
  output logic [CH_W:0]        level,
  output logic [1:0]           fade_state
`ifdef PALETTE_TRANSPARENT_EN
  ,
  output logic                 transparent
`endif
);

  localparam int DEPTH = 2 ** INDEX_W;
  localparam int PW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [1:0] ST_FULL  = 2'd0;
  localparam logic [1:0] ST_OUT   = 2'd1;
  localparam logic [1:0] ST_BLACK = 2'd2;
  localparam logic [1:0] ST_IN    = 2'd3;

  localparam logic [CH_W:0] LVL_MAX  = {1'b1, {CH_W{1'b0}}};
  localparam logic [CH_W:0] LVL_PRE  = {1'b0, {CH_W{1'b1}}};
  localparam logic [CH_W:0] LVL_ONE  = {{CH_W{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PRE_LAST = PW'(FADE_DIV - 1);

  // Scale one channel by the brightness level; no rounding.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c,
                                              input logic [CH_W:0]   l);
    logic [2*CH_W:0] p;
    p = {{(CH_W+1){1'b0}}, c} * {{CH_W{1'b0}}, l};
    return p[2*CH_W-1:CH_W];
  endfunction

  logic [3*CH_W-1:0] pal_q [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [CH_W:0]     level_q, level_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              busy_q;
  logic              fading;
  logic              wr_fire;

  logic              valid1_q;
  logic [3*CH_W-1:0] entry1_q;
  logic              zero1_q;
  logic [CH_W-1:0]   red_q, green_q, blue_q;
  logic              rgb_valid_q;
  logic              transp_q;

  assign fading  = (state_q == ST_OUT) || (state_q == ST_IN);
  assign wr_fire = wr_valid && !fading;

  // Palette storage: accepted writes land on the next edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= '0;
    end else if (wr_fire) begin
      pal_q[wr_addr] <= wr_data;
    end
  end

  // Fade FSM next-state: command decode and per-tick level stepping.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    presc_d = presc_q;
    case (state_q)
      ST_FULL: begin
        if (fade_cmd == 2'b01) begin
          state_d = ST_OUT;
          presc_d = '0;
        end
      end
      ST_BLACK: begin
        if (fade_cmd == 2'b10) begin
          state_d = ST_IN;
          presc_d = '0;
        end
      end
      ST_OUT, ST_IN: begin
        if (frame_tick) begin
          if (presc_q == PRE_LAST) begin
            presc_d = '0;
            if (state_q == ST_OUT) begin
              level_d = level_q - LVL_ONE;
              if (level_q == LVL_ONE) state_d = ST_BLACK;
            end else begin
              level_d = level_q + LVL_ONE;
              if (level_q == LVL_PRE) state_d = ST_FULL;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: state_d = ST_FULL;
    endcase
  end

  // Fade FSM registers; busy is registered from the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_FULL;
      level_q <= LVL_MAX;
      presc_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      presc_q <= presc_d;
      busy_q  <= (state_d == ST_OUT) || (state_d == ST_IN);
    end
  end

  // Stage 1: fetch the palette entry (old value on a same-cycle write).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid1_q <= 1'b0;
      entry1_q <= '0;
      zero1_q  <= 1'b0;
    end else begin
      valid1_q <= pix_valid;
      if (pix_valid) begin
        entry1_q <= pal_q[index];
        zero1_q  <= (index == '0);
      end
    end
  end

  // Stage 2: apply the level seen at this edge; hold data when idle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      rgb_valid_q <= 1'b0;
      transp_q    <= 1'b0;
    end else begin
      rgb_valid_q <= valid1_q;
`ifdef PALETTE_TRANSPARENT_EN
      transp_q    <= valid1_q && zero1_q;
`else
      transp_q    <= 1'b0;
`endif
      if (valid1_q) begin
`ifdef PALETTE_TRANSPARENT_EN
        if (zero1_q) begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
        end else
`endif
        begin
          red_q   <= fade_ch(entry1_q[3*CH_W-1:2*CH_W], level_q);
          green_q <= fade_ch(entry1_q[2*CH_W-1:CH_W], level_q);
          blue_q  <= fade_ch(entry1_q[CH_W-1:0], level_q);
        end
      end
    end
  end

  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign rgb_valid  = rgb_valid_q;
  assign wr_ready   = !fading;
  assign fade_busy  = busy_q;
  assign level      = level_q;
  assign fade_state = state_q;
`ifdef PALETTE_TRANSPARENT_EN
  assign transparent = transp_q;
`else
  logic unused_transp;
  assign unused_transp = transp_q ^ zero1_q;
`endif

endmodule

// File: tb/tb_palette_lut_fader.sv
// Bench for palette_lut_fader: directed steps with randomized data, checked
// against a palette/fade model kept in plain arrays and tick counts.
module tb_palette_lut_fader;

  localparam int INDEX_W  = 5;
  localparam int CH_W     = 4;
  localparam int FADE_DIV = 4;
  localparam int DEPTH    = 32;
  localparam int FULL_LVL = 16;

  localparam int M_FULL  = 0;
  localparam int M_OUT   = 1;
  localparam int M_BLACK = 2;
  localparam int M_IN    = 3;

  logic               Clk;
  logic               Reset_n;
  logic [INDEX_W-1:0] index;
  logic               pix_valid;
  logic [CH_W-1:0]    red, green, blue;
  logic               rgb_valid;
  logic               wr_valid;
  logic               wr_ready;
  logic [INDEX_W-1:0] wr_addr;
  logic [3*CH_W-1:0]  wr_data;
  logic               frame_tick;
  logic [1:0]         fade_cmd;
  logic               fade_busy;
  logic [CH_W:0]      level;
  logic [1:0]         fade_state;
`ifdef PALETTE_TRANSPARENT_EN
  logic               transparent;
`endif

  palette_lut_fader #(.INDEX_W(INDEX_W), .CH_W(CH_W), .FADE_DIV(FADE_DIV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .index(index), .pix_valid(pix_valid),
    .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_tick(frame_tick), .fade_cmd(fade_cmd), .fade_busy(fade_busy),
    .level(level), .fade_state(fade_state)
`ifdef PALETTE_TRANSPARENT_EN
    , .transparent(transparent)
`endif
  );

  // Clock and counters
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: palette contents, fade mode, ticks since fade start
  logic [11:0] m_pal [DEPTH];
  int m_level;
  int m_mode;
  int m_ticks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expect_rgb(input int idx);
    int r, g, b;
`ifdef PALETTE_TRANSPARENT_EN
    if (idx == 0) return 12'h000;
`endif
    r = int'(m_pal[idx][11:8]) * m_level / 16;
    g = int'(m_pal[idx][7:4]) * m_level / 16;
    b = int'(m_pal[idx][3:0]) * m_level / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_pal[i] = 12'h000;
    m_level = FULL_LVL;
    m_mode  = M_FULL;
    m_ticks = 0;
  endfunction

  function automatic void model_cmd(input int c);
    if (m_mode == M_FULL && c == 1) begin m_mode = M_OUT; m_ticks = 0; end
    else if (m_mode == M_BLACK && c == 2) begin m_mode = M_IN; m_ticks = 0; end
  endfunction

  // Level follows directly from how many ticks have passed in the fade.
  function automatic void model_tick();
    if (m_mode == M_OUT || m_mode == M_IN) begin
      m_ticks++;
      if (m_mode == M_OUT) begin
        m_level = FULL_LVL - m_ticks / FADE_DIV;
        if (m_level == 0) m_mode = M_BLACK;
      end else begin
        m_level = m_ticks / FADE_DIV;
        if (m_level == FULL_LVL) m_mode = M_FULL;
      end
    end
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic do_write(input int addr, input logic [11:0] data);
    @(negedge Clk);
    check("wr_ready_idle", wr_ready, 1);
    wr_valid = 1'b1; wr_addr = addr[INDEX_W-1:0]; wr_data = data;
    @(negedge Clk);
    wr_valid = 1'b0;
    m_pal[addr] = data;
  endtask

  task automatic lookup_check(input int idx, input string tag);
    @(negedge Clk);
    index = idx[INDEX_W-1:0]; pix_valid = 1'b1;
    @(negedge Clk);
    pix_valid = 1'b0; index = INDEX_W'($urandom);
    @(negedge Clk);
    check({tag, "_valid"}, rgb_valid, 1);
    check(tag, {red, green, blue}, expect_rgb(idx));
`ifdef PALETTE_TRANSPARENT_EN
    check({tag, "_transp"}, transparent, (idx == 0) ? 1 : 0);
`endif
  endtask

  task automatic do_tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    model_tick();
  endtask

  task automatic do_cmd(input logic [1:0] c);
    @(negedge Clk);
    fade_cmd = c;
    @(negedge Clk);
    fade_cmd = 2'b00;
    model_cmd(int'(c));
  endtask

  task automatic check_fade(input string tag);
    check({tag, "_level"}, level, m_level);
    check({tag, "_busy"}, fade_busy, (m_mode == M_OUT || m_mode == M_IN) ? 1 : 0);
    check({tag, "_state"}, fade_state, m_mode);
  endtask

  // Directed sequence with randomized data
  initial begin
    int idx;
    logic [11:0] d;
    logic [11:0] held;

    Reset_n = 1'b0; index = '0; pix_valid = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; frame_tick = 1'b0; fade_cmd = 2'b00;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset state
    check("rst_rgb_valid", rgb_valid, 0);
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_wr_ready", wr_ready, 1);
    check_fade("rst");
`ifdef PALETTE_TRANSPARENT_EN
    check("rst_transp", transparent, 0);
`endif

    // Basic write then lookup; outputs hold while pix_valid is low
    do_write(7, 12'hF84);
    lookup_check(7, "lut7");
    check("lut7_const", {red, green, blue}, 12'hF84);
    @(negedge Clk);
    check("hold_valid", rgb_valid, 0);
    check("hold_rgb", {red, green, blue}, 12'hF84);

    // Same-cycle write and read returns the old entry
    @(negedge Clk);
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 12'hABC;
    index = 5'd3; pix_valid = 1'b1;
    @(negedge Clk);
    wr_valid = 1'b0; pix_valid = 1'b0;
    @(negedge Clk);
    check("rw_same_old", {red, green, blue}, 12'h000);
    m_pal[3] = 12'hABC;
    lookup_check(3, "rw_same_new");
    check("rw_same_const", {red, green, blue}, 12'hABC);

    // Back-to-back writes, all accepted
    @(negedge Clk);
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 12'h123;
    @(negedge Clk);
    wr_addr = 5'd11; wr_data = 12'h456;
    @(negedge Clk);
    wr_valid = 1'b0;
    m_pal[10] = 12'h123; m_pal[11] = 12'h456;
    lookup_check(10, "b2b_10");
    lookup_check(11, "b2b_11");

    // Random writes and lookups at full brightness
    for (int i = 0; i < 12; i++) begin
      idx = int'($urandom_range(0, DEPTH - 1));
      if (idx == 7 || idx == 9) idx = 12;
      do_write(idx, 12'($urandom));
    end
    for (int i = 0; i < 10; i++) lookup_check(int'($urandom_range(0, DEPTH - 1)), "rand_lut");

    // Fade out
    do_cmd(2'b01);
    check_fade("fo_start");
    check("fo_wr_ready", wr_ready, 0);
    repeat (4) do_tick();
    check_fade("fo_4");
    check("fo_4_lvl_const", level, 15);
    lookup_check(7, "fo_lut7");
    check("fo_lut7_const", {red, green, blue}, 12'hE73);
    for (int t = 5; t <= 64; t++) begin
      do_tick();
      check_fade("fo_tick");
      if (t % 12 == 0) lookup_check(int'($urandom_range(1, DEPTH - 1)), "fo_rand");
    end
    check("fo_end_lvl", level, 0);
    check("fo_end_busy", fade_busy, 0);
    lookup_check(7, "black_lut7");
    check("black_lut7_const", {red, green, blue}, 12'h000);
    do_tick();
    check_fade("black_tick");

    // Fade in with a write held pending and a stray fade-out command
    do_cmd(2'b10);
    check_fade("fi_start");
    d = 12'($urandom);
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = d;
    for (int t = 1; t <= 64; t++) begin
      do_tick();
      if (t == 10) begin
        do_cmd(2'b01);
        check_fade("fi_ignore_cmd");
      end
      if (t < 64) begin
        check_fade("fi_tick");
        check("fi_wr_stall", wr_ready, 0);
      end
    end
    check_fade("fi_end");
    check("fi_end_lvl", level, 16);
    check("fi_wr_ready", wr_ready, 1);
    @(negedge Clk);
    wr_valid = 1'b0;
    m_pal[9] = d;
    lookup_check(9, "fi_wr_done");
    lookup_check(7, "fi_lut7");
    check("fi_lut7_const", {red, green, blue}, 12'hF84);

    // Frame ticks at full brightness do nothing
    repeat (3) do_tick();
    check_fade("full_tick");

    // Reset in the middle of a fade-out
    do_cmd(2'b01);
    repeat (28) do_tick();
    check("mid_lvl9", level, 9);
    @(negedge Clk);
    index = 5'd7; pix_valid = 1'b1;
    @(negedge Clk);
    pix_valid = 1'b0;
    do_reset();
    held = {red, green, blue};
    check("mr_rgb_valid", rgb_valid, 0);
    check("mr_rgb", held, 12'h000);
    check_fade("mr");
    check("mr_lvl_const", level, 16);
    check("mr_wr_ready", wr_ready, 1);
    lookup_check(7, "mr_lut7");
    check("mr_lut7_const", {red, green, blue}, 12'h000);

`ifdef PALETTE_TRANSPARENT_EN
    // Index 0 is transparent and displayed black
    do_write(0, 12'hFFF);
    do_write(1, 12'h5A3);
    lookup_check(0, "tr_idx0");
    check("tr_idx0_const", {red, green, blue}, 12'h000);
    lookup_check(1, "tr_idx1");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/palette_lut_fader.md
Name: palette_lut_fader

Overview:
Writable, parametrised colour palette for the VGA pixel path. It converts a pixel colour index into an RGB triple through a register-based lookup table that software or game logic can rewrite at run time. A frame-synchronous fade engine scales every output channel for fade-to-black and fade-from-black screen transitions. The block sits between sprite/background index generation and the VGA colour outputs.

Parameters:
INDEX_W, 5, width of the colour index; the palette has 2**INDEX_W entries.
CH_W, 4, bits per colour channel.
FADE_DIV, 4, number of frame_tick pulses per fade level step; must be at least 1.

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
index  in  INDEX_W  pixel colour index
pix_valid  in  1  index is valid this cycle
red  out  CH_W  faded red channel
green  out  CH_W  faded green channel
blue  out  CH_W  faded blue channel
rgb_valid  out  1  red/green/blue are valid
wr_valid  in  1  palette write request
wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
wr_addr  in  INDEX_W  entry to write
wr_data  in  3*CH_W  {R,G,B} entry value
frame_tick  in  1  single-cycle pulse, once per frame (vsync)
fade_cmd  in  2  00 none, 01 fade out, 10 fade in, 11 reserved (ignored)
fade_busy  out  1  a fade is in progress
level  out  CH_W+1  current brightness, 0 to 2**CH_W

Behaviour:
- Reset (Reset_n low, asynchronous): all palette entries 0; red/green/blue 0; rgb_valid 0; level = 2**CH_W (full brightness); state FULL; prescaler 0; fade_busy 0; wr_ready 1.
- Lookup pipeline latency is 2 cycles.
  - Stage 1 registers the entry at index.
  - Stage 2 registers the faded channels and rgb_valid = pix_valid delayed by 2.
  - When valid is low, data outputs hold their last value.
- Fade arithmetic, per channel: out = (c * level) >> CH_W. Use a (2*CH_W+1)-bit intermediate and truncate; no rounding.
  - level = 2**CH_W gives the identity.
  - level = 0 gives 0.
- The level value used is the one registered at stage 2 entry. A level change mid-frame affects pixels from the next stage-2 cycle on.
- Writes:
  - wr_ready is 1 except in FADING_OUT and FADING_IN, where it is 0 and requests stall.
  - An accepted write updates the entry at the next clock edge.
  - A read of the same index in the same cycle returns the old value.
  - Multiple writes in consecutive cycles are all accepted.
- Fade FSM states: FULL, FADING_OUT, BLACK, FADING_IN.
  - FULL: fade_cmd=01 moves to FADING_OUT and clears the prescaler. Other commands are ignored.
  - BLACK: fade_cmd=10 moves to FADING_IN and clears the prescaler. Other commands are ignored.
  - FADING_*: fade_cmd is ignored. On each frame_tick the prescaler increments. When it would reach FADE_DIV, it clears and level steps by 1 (down for FADING_OUT, up for FADING_IN).
  - FADING_OUT: when level reaches 0, move to BLACK on the same edge.
  - FADING_IN: when level reaches 2**CH_W, move to FULL on the same edge.
  - A full fade takes FADE_DIV * 2**CH_W frame_ticks.
  - frame_tick outside FADING_* has no effect.
  - fade_busy = (state is FADING_OUT or FADING_IN), registered.
- Reset mid-fade: immediate return to the reset state, full brightness.

Optional Feature:
PALETTE_TRANSPARENT_EN
- Defined:
  - Adds output port transparent (1 bit, reset 0).
  - It equals (index == 0), delayed 2 cycles and qualified by pix_valid, aligned with rgb_valid.
  - When it is asserted, red/green/blue are forced to 0.
  - Entry 0 remains writable but is never displayed.
- Undefined: the transparent port is absent, and index 0 is looked up like any other entry.

Test Plan:
- Write entry 7 = 0xF84 (wr_valid=1 for 1 cycle), then present index=7 with pix_valid=1 -> two cycles later rgb_valid=1, {red,green,blue} = {F,8,4}.
- Same cycle: write entry 3 = 0xABC and present index=3 -> output shows the old value 0x000. The next lookup of index 3 shows {A,B,C}.
- Entry 7 = 0xF84, FADE_DIV=4, fade_cmd=01, then 4 frame_ticks -> level goes 16 to 15, fade_busy=1, index 7 outputs {E,7,3}. After 64 ticks total -> level=0, state BLACK, output {0,0,0}, fade_busy=0.
- From BLACK, fade_cmd=10 plus 64 frame_ticks -> level=16, output {F,8,4}. fade_cmd=01 issued during the fade-in is ignored. wr_valid held high during the fade -> wr_ready=0 until the fade ends, then the write is accepted.
- Assert Reset_n=0 for 1 cycle mid fade-out (level=9) -> level=16, fade_busy=0, rgb_valid=0, index 7 then reads 0x000.
- With PALETTE_TRANSPARENT_EN: entry 0 = 0xFFF, index=0 -> transparent=1 and output {0,0,0}. Index 1 -> transparent=0.
